req_gnt_rr_arbiter: RTL and testbench
=====================================

// Module: req_gnt_rr_arbiter
// PURPOSE
//   Round-robin arbiter sharing one resource among NUM_REQ requesters over a
//   level req/gnt handshake. A grant is held until the owner drops req, or is
//   revoked after MAX_HOLD cycles. Sits in front of the shared resource and
//   drives the gnt side of the req |-> ##[1:$] gnt protocol for every requester.
// PARAMETERS
//   NUM_REQ   4   number of requesters (2..16)
//   MAX_HOLD  16  max consecutive cycles one owner may hold gnt (>=2)
// PORTS
//   clk         in   1           clock, all logic on posedge
//   reset       in   1           synchronous, active-high reset
//   req         in   NUM_REQ     level request per requester
//   gnt         out  NUM_REQ     one-hot-or-zero grant, registered
//   gnt_id      out  $clog2(NUM_REQ)  index of current owner (valid when busy)
//   busy        out  1           resource owned (|gnt)
//   revoke      out  1           1-cycle pulse: grant forcibly removed by timeout
//   revoked     out  NUM_REQ     sticky mask: requester revoked, ineligible
// BEHAVIOUR
//   Reset (sampled at posedge): gnt=0, gnt_id=0, busy=0, revoke=0, revoked=0,
//     state=IDLE, rr pointer=0, hold counter=0. Reset mid-grant drops gnt on that edge.
//   States: IDLE -> GRANT -> RELEASE -> IDLE.
//   IDLE: eligible = req & ~revoked. If eligible!=0, pick first set bit
//     searching upward from rr pointer with wrap (ptr, ptr+1, .., NUM_REQ-1, 0..).
//     gnt[w] rises on that same edge; latency = 1 cycle from req sampled high.
//     Hold counter loads 1. eligible==0: stay IDLE, gnt=0.
//   GRANT: while req[owner]=1 and hold<MAX_HOLD: keep gnt, hold++ (saturating).
//     req[owner] sampled 0 -> gnt=0 next edge, go RELEASE, no revoke.
//     req[owner]=1 and hold==MAX_HOLD -> gnt=0, revoke pulses 1 cycle,
//     revoked[owner] set, go RELEASE. gnt therefore high at most MAX_HOLD cycles.
//     Other requesters' req changes ignored in GRANT (no preemption).
//   RELEASE: exactly one cycle with gnt=0 (bus turnaround); rr ptr <= owner+1
//     mod NUM_REQ; go IDLE. Back-to-back owners always separated by 1 idle cycle.
//   revoked[i] clears on the first edge req[i] is sampled 0; a revoked
//     requester must drop req for >=1 cycle before it can win again.
//   Simultaneous: drop of req[owner] on the same cycle hold==MAX_HOLD counts as
//     normal release (no revoke). Multiple new reqs in IDLE: rr order decides.
//   Fairness: with all NUM_REQ requesting continuously, each is granted once per
//     NUM_REQ grants; worst-case wait = (NUM_REQ-1)*(MAX_HOLD+1)+1 cycles.
//   Invariants: $onehot0(gnt); gnt[i] -> req[i] was 1 previous cycle;
//     busy == |gnt; gnt_id == index of set gnt bit when busy.
// TESTING (NUM_REQ=4, MAX_HOLD=8)
//   1. Reset 10 cycles, req=4'b0000 -> gnt=0, busy=0, revoke=0 throughout.
//   2. req=4'b0100 held 3 cycles then 0 -> gnt=4'b0100 one cycle after req,
//      held 3 cycles, drops one cycle after req drops; 1 idle cycle; ptr=3.
//   3. req=4'b1111 constant, owners release after 2 cycles each -> grant order
//      0,1,2,3,0 with exactly 1 idle cycle between owners.
//   4. req=4'b0010 held 20 cycles -> gnt[1] high 8 cycles, revoke pulse,
//      revoked=4'b0010, no regrant until req[1] low 1 cycle and high again.
//   5. req[0] held, assert reset during GRANT -> next edge gnt=0, revoked=0,
//      ptr=0; after reset release req[0] regranted 1 cycle later.
//   6. Owner drops req on the cycle hold reaches 8 -> normal release, revoke=0.

Source files
------------

// File: rtl/req_gnt_rr_arbiter_if.sv
// Level req/gnt handshake bundle between NUM_REQ requesters and the round-robin arbiter.
// The arbiter connects through the slave modport and the requester side through the master modport.
interface req_gnt_rr_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_id;
    logic               busy;
    logic               revoke;
    logic [NUM_REQ-1:0] revoked;

    modport master (
        output req,
        input  gnt, gnt_id, busy, revoke, revoked
    );

    modport slave (
        input  req,
        output gnt, gnt_id, busy, revoke, revoked
    );
endinterface

// File: rtl/req_gnt_rr_arbiter.sv
// Round-robin arbiter for one shared resource: level req/gnt, grant held until release,
// forcibly revoked after MAX_HOLD cycles with a sticky per-requester revoked mask.
module req_gnt_rr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    req_gnt_rr_arbiter_if.slave  bus
);
    localparam int ID_W   = $clog2(NUM_REQ);
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RELEASE
    } state_t;

    state_t             state_q;
    logic [ID_W-1:0]    ptr_q;
    logic [HOLD_W-1:0]  hold_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic [ID_W-1:0]    gnt_id_q;
    logic               busy_q;
    logic               revoke_q;
    logic [NUM_REQ-1:0] revoked_q;

    logic [NUM_REQ-1:0] eligible;
    logic [ID_W-1:0]    next_ptr;
    logic [ID_W-1:0]    arb_base;
    logic               pick_found;
    logic [ID_W-1:0]    pick_id;
    int                 idx;

    assign eligible = bus.req & ~revoked_q;
    assign next_ptr = (gnt_id_q == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id_q + 1'b1;
    // RELEASE arbitrates with the already-rotated pointer so the turnaround gap is exactly one cycle.
    assign arb_base = (state_q == RELEASE) ? next_ptr : ptr_q;

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        pick_found = 1'b0;
        pick_id    = '0;
        idx        = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(arb_base) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!pick_found && eligible[ID_W'(idx)]) begin
                pick_found = 1'b1;
                pick_id    = ID_W'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking everywhere so each register samples pre-edge values.
        if (reset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            hold_q    <= '0;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            busy_q    <= 1'b0;
            revoke_q  <= 1'b0;
            revoked_q <= '0;
        end else begin
            revoke_q  <= 1'b0;
            revoked_q <= revoked_q & bus.req;

            case (state_q)
                IDLE, RELEASE: begin
                    if (state_q == RELEASE) ptr_q <= next_ptr;
                    if (pick_found) begin
                        gnt_q    <= NUM_REQ'(1) << pick_id;
                        gnt_id_q <= pick_id;
                        busy_q   <= 1'b1;
                        hold_q   <= HOLD_W'(1);
                        state_q  <= GRANT;
                    end else begin
                        state_q  <= IDLE;
                    end
                end

                GRANT: begin
                    // A drop of req wins over a simultaneous timeout: normal release.
                    if (!bus.req[gnt_id_q]) begin
                        gnt_q   <= '0;
                        busy_q  <= 1'b0;
                        hold_q  <= '0;
                        state_q <= RELEASE;
                    end else if (hold_q == HOLD_W'(MAX_HOLD)) begin
                        gnt_q     <= '0;
                        busy_q    <= 1'b0;
                        hold_q    <= '0;
                        revoke_q  <= 1'b1;
                        revoked_q <= (revoked_q & bus.req) | gnt_q;
                        state_q   <= RELEASE;
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.gnt_id  = gnt_id_q;
    assign bus.busy    = busy_q;
    assign bus.revoke  = revoke_q;
    assign bus.revoked = revoked_q;
endmodule

// File: tb/tb_req_gnt_rr_arbiter.sv
// Self-checking bench for req_gnt_rr_arbiter (NUM_REQ=4, MAX_HOLD=8): cycle vector table
// through a scoreboard queue, plus a hand-written round-robin rotation sequence.
module tb_req_gnt_rr_arbiter;
    localparam int N  = 4;
    localparam int MH = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    req_gnt_rr_arbiter_if #(.NUM_REQ(N)) bus ();

    req_gnt_rr_arbiter #(.NUM_REQ(N), .MAX_HOLD(MH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       busy;
        logic       revoke;
        logic [3:0] revoked;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    vec_t e;
    int   n_checks = 0;
    int   n_pass   = 0;

    int         order_q[$];
    int         exp_id;
    int         hold_cnt;
    int         idle_cnt;
    int         cyc;
    bit         first;
    logic [3:0] prev_gnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic void add(input logic r, input logic [3:0] rq, input logic [3:0] g,
                                input logic [1:0] id, input logic b, input logic rv,
                                input logic [3:0] rvd);
        vec_t v;
        v.rst = r; v.req = rq; v.gnt = g; v.id = id; v.busy = b; v.revoke = rv; v.revoked = rvd;
        vecs.push_back(v);
    endfunction

    initial begin
        // Reset held 10 cycles with no requests.
        for (int i = 0; i < 10; i++) add(1, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000);
        // Single requester 2 for three cycles, then pointer must sit at 3.
        for (int i = 0; i < 3; i++) add(0, 4'b0100, 4'b0100, 2, 1, 0, 4'b0000);
        add(0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000);
        add(0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000);
        add(0, 4'b1001, 4'b1000, 3, 1, 0, 4'b0000);
        add(0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000);
        add(0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000);
        // Requester 1 holds req 20 cycles: 8 granted, revoke, then locked out.
        for (int i = 0; i < MH; i++) add(0, 4'b0010, 4'b0010, 1, 1, 0, 4'b0000);
        add(0, 4'b0010, 4'b0000, 0, 0, 1, 4'b0010);
        for (int i = 0; i < 11; i++) add(0, 4'b0010, 4'b0000, 0, 0, 0, 4'b0010);
        // Revoked 1 skipped in favour of 0; reset mid-grant clears everything.
        add(0, 4'b0011, 4'b0001, 0, 1, 0, 4'b0010);
        add(0, 4'b0011, 4'b0001, 0, 1, 0, 4'b0010);
        add(1, 4'b0011, 4'b0000, 0, 0, 0, 4'b0000);
        add(0, 4'b0011, 4'b0001, 0, 1, 0, 4'b0000);
        add(0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000);
        add(0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000);
        // Owner drops req exactly when hold reaches MAX_HOLD: plain release.
        for (int i = 0; i < MH; i++) add(0, 4'b0001, 4'b0001, 0, 1, 0, 4'b0000);
        add(0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000);
        add(0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000);
        add(0, 4'b0001, 4'b0001, 0, 1, 0, 4'b0000);
        add(0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000);
        add(0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000);

        reset   = 1'b1;
        bus.req = '0;

        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge clk);
            reset   = vecs[k].rst;
            bus.req = vecs[k].req;
            sb.push_back(vecs[k]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check($sformatf("gnt[v%0d]", k),     bus.gnt,     e.gnt);
            check($sformatf("busy[v%0d]", k),    bus.busy,    e.busy);
            check($sformatf("revoke[v%0d]", k),  bus.revoke,  e.revoke);
            check($sformatf("revoked[v%0d]", k), bus.revoked, e.revoked);
            if (e.busy) check($sformatf("gnt_id[v%0d]", k), bus.gnt_id, e.id);
        end

        // All four requesting; each owner releases after 2 cycles and re-requests next cycle.
        @(negedge clk);
        reset   = 1'b1;
        bus.req = '0;
        repeat (2) @(negedge clk);
        reset   = 1'b0;
        bus.req = 4'b1111;
        order_q  = '{0, 1, 2, 3, 0};
        hold_cnt = 0;
        idle_cnt = 0;
        cyc      = 0;
        first    = 1'b1;
        prev_gnt = '0;
        while (order_q.size() > 0 && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.gnt != 4'b0000) begin
                if (prev_gnt == 4'b0000) begin
                    exp_id = order_q.pop_front();
                    check("rr_gnt", bus.gnt, 32'(1) << exp_id);
                    if (!first) check("rr_turnaround", idle_cnt, 1);
                    first    = 1'b0;
                    hold_cnt = 1;
                    idle_cnt = 0;
                end else begin
                    hold_cnt++;
                end
            end else begin
                if (prev_gnt != 4'b0000) check("rr_hold_len", hold_cnt, 2);
                idle_cnt++;
            end
            prev_gnt = bus.gnt;
            @(negedge clk);
            bus.req = (bus.gnt != 4'b0000 && hold_cnt == 2) ? ~bus.gnt : 4'b1111;
        end
        check("rr_all_granted", order_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
